gpio_irq_ip: RTL and testbench

Next-generation memory-mapped GPIO block for the SoC peripheral bus. Each pin has a direction control and a tri-state driver. Inputs pass through a 2-flop synchroniser and feed per-pin rising/falling edge detectors. Detected edges set sticky status bits, which drive one level-sensitive interrupt line. Atomic SET/CLR/TGL write ports let firmware change pins without a read-modify-write.

---
 rtl/gpio_irq_ip.sv | 179 +++++++++++++++++
 tb/tb_gpio_irq_ip.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_irq_ip.sv
// Memory-mapped GPIO with per-pin direction, 2-flop input sync, edge-detect sticky status and one level IRQ.
// Latency: writes land on the next clock edge, reads are combinational, pin->READ 2 clocks (+DEBOUNCE_CYCLES with filter).
// Backpressure: none; the bus never stalls. Optional input filter is compiled in with `define GPIO_DEBOUNCE_EN.
module gpio_irq_ip #(
  parameter int ADDR_WIDTH      = 6,
  parameter int DATA_WIDTH      = 32,
  parameter int GPIO_WIDTH      = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_sel,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_irq,
  inout  wire  [GPIO_WIDTH-1:0] gpio_pins
);

  // Elaboration-time parameter sanity checks.
  if (ADDR_WIDTH < 6) begin : g_bad_addr_width
    $error("gpio_irq_ip: ADDR_WIDTH must be >= 6");
  end
  if (GPIO_WIDTH < 1 || GPIO_WIDTH > DATA_WIDTH) begin : g_bad_gpio_width
    $error("gpio_irq_ip: GPIO_WIDTH must be in 1..DATA_WIDTH");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("gpio_irq_ip: DEBOUNCE_CYCLES must be >= 1");
  end

  localparam logic [ADDR_WIDTH-1:0] A_DATA    = ADDR_WIDTH'(8'h00);
  localparam logic [ADDR_WIDTH-1:0] A_DIR     = ADDR_WIDTH'(8'h04);
  localparam logic [ADDR_WIDTH-1:0] A_READ    = ADDR_WIDTH'(8'h08);
  localparam logic [ADDR_WIDTH-1:0] A_SET     = ADDR_WIDTH'(8'h0C);
  localparam logic [ADDR_WIDTH-1:0] A_CLR     = ADDR_WIDTH'(8'h10);
  localparam logic [ADDR_WIDTH-1:0] A_TGL     = ADDR_WIDTH'(8'h14);
  localparam logic [ADDR_WIDTH-1:0] A_RISE_EN = ADDR_WIDTH'(8'h18);
  localparam logic [ADDR_WIDTH-1:0] A_FALL_EN = ADDR_WIDTH'(8'h1C);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS  = ADDR_WIDTH'(8'h20);
  localparam logic [ADDR_WIDTH-1:0] A_IRQ_EN  = ADDR_WIDTH'(8'h24);

  logic [GPIO_WIDTH-1:0] data_q, data_d;
  logic [GPIO_WIDTH-1:0] dir_q, dir_d;
  logic [GPIO_WIDTH-1:0] rise_en_q, rise_en_d;
  logic [GPIO_WIDTH-1:0] fall_en_q, fall_en_d;
  logic [GPIO_WIDTH-1:0] status_q, status_d;
  logic                  irq_en_q, irq_en_d;
  logic                  irq_q, irq_d;
  logic [GPIO_WIDTH-1:0] s1_q, s2_q, prev_q;
  logic [GPIO_WIDTH-1:0] cond;
  logic [GPIO_WIDTH-1:0] rise, fall, w1c_mask, wd;
  logic                  wr;

  // Upper write-data bits beyond the pin count have no destination.
  logic [DATA_WIDTH-1:0] unused_wdata;
  assign unused_wdata = i_wdata;

  // Pad drivers: output-enabled pins drive the latch, others float.
  for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_pad
    assign gpio_pins[i] = dir_q[i] ? data_q[i] : 1'bz;
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0]      cnt_q [GPIO_WIDTH];
  logic [CNT_W-1:0]      cnt_d [GPIO_WIDTH];
  logic [GPIO_WIDTH-1:0] filt_q, filt_d;

  // Per-pin filter: count while the synchronised value disagrees, accept it once it has held long enough.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < GPIO_WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          filt_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Filter state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      filt_q <= '0;
      for (int i = 0; i < GPIO_WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      filt_q <= filt_d;
      for (int i = 0; i < GPIO_WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign cond = filt_q;
`else
  assign cond = s2_q;
`endif

  assign rise = cond & ~prev_q;
  assign fall = ~cond & prev_q;

  // Register next-state: bus writes, atomic SET/CLR/TGL, W1C status with set priority, flopped IRQ.
  always_comb begin
    wr        = i_sel & i_we;
    wd        = i_wdata[GPIO_WIDTH-1:0];
    data_d    = data_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    irq_en_d  = irq_en_q;
    w1c_mask  = '0;
    if (wr) begin
      case (i_addr)
        A_DATA:    data_d    = wd;
        A_DIR:     dir_d     = wd;
        A_SET:     data_d    = data_q | wd;
        A_CLR:     data_d    = data_q & ~wd;
        A_TGL:     data_d    = data_q ^ wd;
        A_RISE_EN: rise_en_d = wd;
        A_FALL_EN: fall_en_d = wd;
        A_STATUS:  w1c_mask  = wd;
        A_IRQ_EN:  irq_en_d  = i_wdata[0];
        default:   ;
      endcase
    end
    status_d = (status_q & ~w1c_mask) | (rise & rise_en_q) | (fall & fall_en_q);
    irq_d    = irq_en_d & (|status_d);
  end

  // Control/status registers, synchroniser and edge-history flops.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_q    <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
      s1_q      <= '0;
      s2_q      <= '0;
      prev_q    <= '0;
    end else begin
      data_q    <= data_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
      s1_q      <= gpio_pins;
      s2_q      <= s1_q;
      prev_q    <= cond;
    end
  end

  assign o_irq = irq_q;

  // Read mux: only active for a selected read; write-only and unmapped offsets return zero.
  always_comb begin
    o_rdata = '0;
    if (i_sel && !i_we) begin
      case (i_addr)
        A_DATA:    o_rdata = DATA_WIDTH'(data_q);
        A_DIR:     o_rdata = DATA_WIDTH'(dir_q);
        A_READ:    o_rdata = DATA_WIDTH'(cond);
        A_RISE_EN: o_rdata = DATA_WIDTH'(rise_en_q);
        A_FALL_EN: o_rdata = DATA_WIDTH'(fall_en_q);
        A_STATUS:  o_rdata = DATA_WIDTH'(status_q);
        A_IRQ_EN:  o_rdata = DATA_WIDTH'(irq_en_q);
        default:   o_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_irq_ip.sv
// Directed bench for gpio_irq_ip: register access, edge interrupts, W1C race, IRQ gating, async reset, debounce.
// Latency: expectations follow 2-clock sync (+16 when GPIO_DEBOUNCE_EN is defined).
// Backpressure: none on this bus.
module tb_gpio_irq_ip;

`ifdef GPIO_DEBOUNCE_EN
  localparam int FLT = 16;
`else
  localparam int FLT = 0;
`endif

  localparam logic [5:0] A_DATA = 6'h00, A_DIR = 6'h04, A_READ = 6'h08, A_SET = 6'h0C;
  localparam logic [5:0] A_CLR = 6'h10, A_TGL = 6'h14, A_RISE = 6'h18, A_FALL = 6'h1C;
  localparam logic [5:0] A_STAT = 6'h20, A_IRQ = 6'h24;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        i_sel = 1'b0;
  logic        i_we = 1'b0;
  logic [5:0]  i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic [31:0] o_rdata;
  logic        o_irq;
  wire  [7:0]  pins;
  logic [7:0]  tb_oe = 8'hFF;
  logic [7:0]  tb_drv = 8'h00;
  int          pass_cnt = 0;
  int          chk_cnt = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 8; g++) begin : g_drv
    assign pins[g] = tb_oe[g] ? tb_drv[g] : 1'bz;
  end

  gpio_irq_ip #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .GPIO_WIDTH(8), .DEBOUNCE_CYCLES(16)) dut (
    .clk(clk), .resetn(resetn), .i_sel(i_sel), .i_we(i_we), .i_addr(i_addr),
    .i_wdata(i_wdata), .o_rdata(o_rdata), .o_irq(o_irq), .gpio_pins(pins)
  );

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    i_sel = 1'b1; i_we = 1'b1; i_addr = a; i_wdata = d;
    @(posedge clk); #1;
    i_sel = 1'b0; i_we = 1'b0; i_wdata = '0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d);
    i_sel = 1'b1; i_we = 1'b0; i_addr = a;
    #1 d = o_rdata;
    i_sel = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    #3;
    for (int k = 0; k < 10; k++) begin
      rd(6'(k * 4), r);
      chk_cnt++;
      if (r !== 32'h0) $display("FAIL reset_reg_%02h got %h exp %h", k * 4, r, 32'h0); else pass_cnt++;
    end
    chk_cnt++;
    if (o_irq !== 1'b0) $display("FAIL reset_irq got %b exp 0", o_irq); else pass_cnt++;
    @(negedge clk); resetn = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_data_ops();
    logic [31:0] r;
    tb_oe = 8'h00;
    wr(A_DIR, 32'hFF);
    repeat (3 + FLT) @(posedge clk);
    wr(A_DATA, 32'hA5);
    chk_cnt++;
    if (pins !== 8'hA5) $display("FAIL pins_drive got %h exp a5", pins); else pass_cnt++;
    repeat (1 + FLT) @(posedge clk); #1;
    rd(A_READ, r);
    chk_cnt++;
    if (r !== 32'h0) $display("FAIL read_early got %h exp 0", r); else pass_cnt++;
    @(posedge clk); #1;
    rd(A_READ, r);
    chk_cnt++;
    if (r !== 32'hA5) $display("FAIL read_lat got %h exp a5", r); else pass_cnt++;
    wr(A_SET, 32'h0A); rd(A_DATA, r);
    chk_cnt++;
    if (r !== 32'hAF) $display("FAIL set got %h exp af", r); else pass_cnt++;
    wr(A_CLR, 32'h81); rd(A_DATA, r);
    chk_cnt++;
    if (r !== 32'h2E) $display("FAIL clr got %h exp 2e", r); else pass_cnt++;
    wr(A_TGL, 32'hFF); rd(A_DATA, r);
    chk_cnt++;
    if (r !== 32'hD1) $display("FAIL tgl got %h exp d1", r); else pass_cnt++;
    chk_cnt++;
    if (pins !== 8'hD1) $display("FAIL pins_tgl got %h exp d1", pins); else pass_cnt++;
  endtask

  task automatic test_rise_irq();
    logic [31:0] r;
    tb_drv = 8'hD1; tb_oe = 8'hFF;
    wr(A_DIR, 32'h0);
    tb_drv = 8'h00;
    repeat (6 + FLT) @(posedge clk);
    wr(A_RISE, 32'h01);
    wr(A_IRQ, 32'h1);
    rd(A_STAT, r);
    chk_cnt++;
    if (r !== 32'h0) $display("FAIL rise_pre_status got %h exp 0", r); else pass_cnt++;
    @(negedge clk); tb_drv[0] = 1'b1;
    repeat (2 + FLT) @(posedge clk); #1;
    rd(A_READ, r);
    chk_cnt++;
    if (r !== 32'h01) $display("FAIL rise_read got %h exp 01", r); else pass_cnt++;
    rd(A_STAT, r);
    chk_cnt++;
    if (r !== 32'h0 || o_irq !== 1'b0) $display("FAIL rise_edge2 got status %h irq %b exp 0 0", r, o_irq); else pass_cnt++;
    @(posedge clk); #1;
    rd(A_STAT, r);
    chk_cnt++;
    if (r !== 32'h01) $display("FAIL rise_status got %h exp 01", r); else pass_cnt++;
    chk_cnt++;
    if (o_irq !== 1'b1) $display("FAIL rise_irq got %b exp 1", o_irq); else pass_cnt++;
    wr(A_STAT, 32'h01);
    chk_cnt++;
    if (o_irq !== 1'b0) $display("FAIL w1c_irq got %b exp 0", o_irq); else pass_cnt++;
    rd(A_STAT, r);
    chk_cnt++;
    if (r !== 32'h0) $display("FAIL w1c_status got %h exp 0", r); else pass_cnt++;
  endtask

  task automatic test_w1c_race();
    logic [31:0] r;
    wr(A_FALL, 32'h80);
    @(negedge clk); tb_drv[7] = 1'b1;
    repeat (4 + FLT) @(posedge clk);
    @(negedge clk); tb_drv[7] = 1'b0;
    repeat (2 + FLT) @(posedge clk);
    wr(A_STAT, 32'h80);
    rd(A_STAT, r);
    chk_cnt++;
    if (r !== 32'h80) $display("FAIL race_status got %h exp 80", r); else pass_cnt++;
    chk_cnt++;
    if (o_irq !== 1'b1) $display("FAIL race_irq got %b exp 1", o_irq); else pass_cnt++;
    wr(A_STAT, 32'h80);
    rd(A_STAT, r);
    chk_cnt++;
    if (r !== 32'h0) $display("FAIL race_clear got %h exp 0", r); else pass_cnt++;
  endtask

  task automatic test_irq_gate();
    logic [31:0] r;
    wr(A_IRQ, 32'h0);
    wr(A_RISE, 32'h04);
    @(negedge clk); tb_drv[2] = 1'b1;
    repeat (4 + FLT) @(posedge clk); #1;
    rd(A_STAT, r);
    chk_cnt++;
    if (r !== 32'h04) $display("FAIL gate_status got %h exp 04", r); else pass_cnt++;
    chk_cnt++;
    if (o_irq !== 1'b0) $display("FAIL gate_off_irq got %b exp 0", o_irq); else pass_cnt++;
    wr(A_IRQ, 32'h1);
    chk_cnt++;
    if (o_irq !== 1'b1) $display("FAIL gate_on_irq got %b exp 1", o_irq); else pass_cnt++;
    wr(A_RISE, 32'h0);
    rd(A_STAT, r);
    chk_cnt++;
    if (r !== 32'h04) $display("FAIL en_off_keeps got %h exp 04", r); else pass_cnt++;
    rd(6'h28, r);
    chk_cnt++;
    if (r !== 32'h0) $display("FAIL unmapped_28 got %h exp 0", r); else pass_cnt++;
    rd(6'h3C, r);
    chk_cnt++;
    if (r !== 32'h0) $display("FAIL unmapped_3c got %h exp 0", r); else pass_cnt++;
    i_sel = 1'b0; i_we = 1'b0; i_addr = A_STAT; #1;
    chk_cnt++;
    if (o_rdata !== 32'h0) $display("FAIL nosel_rdata got %h exp 0", o_rdata); else pass_cnt++;
    wr(6'h28, 32'hFF);
    wr(A_READ, 32'hFF);
    rd(A_DATA, r);
    chk_cnt++;
    if (r !== 32'hD1) $display("FAIL ignored_wr got %h exp d1", r); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    logic [31:0] r;
    wr(A_DATA, 32'hA5);
    tb_drv = 8'hA5;
    wr(A_DIR, 32'hFF);
    tb_oe = 8'h00;
    #1;
    chk_cnt++;
    if (pins !== 8'hA5) $display("FAIL pre_rst_pins got %h exp a5", pins); else pass_cnt++;
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    chk_cnt++;
    if (o_irq !== 1'b0) $display("FAIL arst_irq got %b exp 0", o_irq); else pass_cnt++;
    rd(A_STAT, r);
    chk_cnt++;
    if (r !== 32'h0) $display("FAIL arst_status got %h exp 0", r); else pass_cnt++;
    rd(A_DIR, r);
    chk_cnt++;
    if (r !== 32'h0) $display("FAIL arst_dir got %h exp 0", r); else pass_cnt++;
    tb_drv = 8'h3C; tb_oe = 8'hFF;
    #1;
    chk_cnt++;
    if (pins !== 8'h3C) $display("FAIL arst_pins_z got %h exp 3c", pins); else pass_cnt++;
    repeat (2) @(posedge clk);
    tb_drv = 8'h00;
    @(negedge clk); resetn = 1'b1;
  endtask

`ifdef GPIO_DEBOUNCE_EN
  task automatic test_debounce();
    logic [31:0] r;
    logic [31:0] seen;
    logic [31:0] r17;
    logic [31:0] r18;
    seen = '0; r17 = '0; r18 = '0;
    repeat (40) @(posedge clk);
    wr(A_RISE, 32'h04);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) tb_drv[2] = 1'b1;
      if (k == 10) tb_drv[2] = 1'b0;
      @(posedge clk); #1;
      rd(A_READ, r);
      seen = seen | r;
    end
    chk_cnt++;
    if (seen[2] !== 1'b0) $display("FAIL glitch_read got %b exp 0", seen[2]); else pass_cnt++;
    rd(A_STAT, r);
    chk_cnt++;
    if (r !== 32'h0) $display("FAIL glitch_status got %h exp 0", r); else pass_cnt++;
    @(negedge clk); tb_drv[2] = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk); #1;
      rd(A_READ, r);
      if (k == 17) r17 = r;
      if (k == 18) r18 = r;
    end
    chk_cnt++;
    if (r17[2] !== 1'b0) $display("FAIL deb_edge17 got %b exp 0", r17[2]); else pass_cnt++;
    chk_cnt++;
    if (r18[2] !== 1'b1) $display("FAIL deb_edge18 got %b exp 1", r18[2]); else pass_cnt++;
    repeat (2) @(posedge clk); #1;
    rd(A_STAT, r);
    chk_cnt++;
    if (r !== 32'h04) $display("FAIL deb_status got %h exp 04", r); else pass_cnt++;
    @(negedge clk); tb_drv[2] = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_data_ops();
    test_rise_irq();
    test_w1c_race();
    test_irq_gate();
    test_async_reset();
`ifdef GPIO_DEBOUNCE_EN
    test_debounce();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout after %0d of %0d checks passed, exp completion", pass_cnt, chk_cnt);
    $fatal(1, "timeout");
  end

endmodule
